// File: rtl/dht11_frame_assembler.sv
// DHT11 frame assembler.
// Collects 40 decoded bits from the bit receiver, verifies the checksum byte,
// and publishes the humidity and temperature bytes with one-cycle status pulses.
// It also aborts a frame on a long inter-bit gap and keeps ok/error counters.
module dht11_frame_assembler #(
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       bit_valid,
  input  logic       bit_value,
  output logic [7:0] humidity_int,
  output logic [7:0] humidity_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       data_valid,
  output logic       checksum_error,
  output logic       timeout_error,
  output logic       busy,
  output logic [7:0] ok_count,
  output logic [7:0] err_count
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0] BIT_LAST = 6'd39;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [39:0]      shift_q, shift_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       hum_int_q, hum_int_d;
  logic [7:0]       hum_dec_q, hum_dec_d;
  logic [7:0]       tmp_int_q, tmp_int_d;
  logic [7:0]       tmp_dec_q, tmp_dec_d;
  logic             data_valid_q, data_valid_d;
  logic             cs_err_q, cs_err_d;
  logic             to_err_q, to_err_d;
  logic [7:0]       ok_cnt_q, ok_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  // Frame bytes as seen in the CHECK cycle; byte 0 arrived first.
  logic [7:0] b0, b1, b2, b3, b4;
  logic [7:0] sum;
  logic [7:0] err_inc;

  assign b0      = shift_q[39:32];
  assign b1      = shift_q[31:24];
  assign b2      = shift_q[23:16];
  assign b3      = shift_q[15:8];
  assign b4      = shift_q[7:0];
  assign sum     = b0 + b1 + b2 + b3;
  // Error counter holds at its maximum instead of wrapping.
  assign err_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; frame_start always wins over a coincident bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (frame_start) begin
          state_d = S_COLLECT;
        end else if (bit_valid) begin
          if (bit_cnt_q == BIT_LAST) state_d = S_CHECK;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        state_d = frame_start ? S_COLLECT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Busy is a pure decode of the state register.
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Datapath next-state: shifting, gap supervision, checksum and counters.
  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    hum_int_d    = hum_int_q;
    hum_dec_d    = hum_dec_q;
    tmp_int_d    = tmp_int_q;
    tmp_dec_d    = tmp_dec_q;
    ok_cnt_d     = ok_cnt_q;
    err_cnt_d    = err_cnt_q;
    data_valid_d = 1'b0;
    cs_err_d     = 1'b0;
    to_err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end
      end
      S_COLLECT: begin
        if (frame_start) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end else if (bit_valid) begin
          shift_d   = {shift_q[38:0], bit_value};
          bit_cnt_d = bit_cnt_q + 6'd1;
          gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_LAST) begin
          to_err_d  = 1'b1;
          err_cnt_d = err_inc;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      S_CHECK: begin
        if (sum == b4) begin
          hum_int_d    = b0;
          hum_dec_d    = b1;
          tmp_int_d    = b2;
          tmp_dec_d    = b3;
          data_valid_d = 1'b1;
          ok_cnt_d     = ok_cnt_q + 8'd1;
        end else begin
          cs_err_d  = 1'b1;
          err_cnt_d = err_inc;
        end
        // A back-to-back frame may start while the result is being reported.
        if (frame_start) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      hum_int_q    <= '0;
      hum_dec_q    <= '0;
      tmp_int_q    <= '0;
      tmp_dec_q    <= '0;
      data_valid_q <= 1'b0;
      cs_err_q     <= 1'b0;
      to_err_q     <= 1'b0;
      ok_cnt_q     <= '0;
      err_cnt_q    <= '0;
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      hum_int_q    <= hum_int_d;
      hum_dec_q    <= hum_dec_d;
      tmp_int_q    <= tmp_int_d;
      tmp_dec_q    <= tmp_dec_d;
      data_valid_q <= data_valid_d;
      cs_err_q     <= cs_err_d;
      to_err_q     <= to_err_d;
      ok_cnt_q     <= ok_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign humidity_int   = hum_int_q;
  assign humidity_dec   = hum_dec_q;
  assign temp_int       = tmp_int_q;
  assign temp_dec       = tmp_dec_q;
  assign data_valid     = data_valid_q;
  assign checksum_error = cs_err_q;
  assign timeout_error  = to_err_q;
  assign ok_count       = ok_cnt_q;
  assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_dht11_frame_assembler.sv
// Testbench for dht11_frame_assembler (TIMEOUT_CYCLES = 50).
// Frames from a vector table plus hand-built corner sequences; every expected
// pulse is queued when stimulus is driven and checked when the DUT pulses.
module tb_dht11_frame_assembler;

  localparam int TO = 50;
  localparam int K_DV = 0;
  localparam int K_CS = 1;
  localparam int K_TO = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       bit_valid;
  logic       bit_value;
  logic [7:0] humidity_int, humidity_dec, temp_int, temp_dec;
  logic       data_valid, checksum_error, timeout_error, busy;
  logic [7:0] ok_count, err_count;

  dht11_frame_assembler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .bit_valid     (bit_valid),
    .bit_value     (bit_value),
    .humidity_int  (humidity_int),
    .humidity_dec  (humidity_dec),
    .temp_int      (temp_int),
    .temp_dec      (temp_dec),
    .data_valid    (data_valid),
    .checksum_error(checksum_error),
    .timeout_error (timeout_error),
    .busy          (busy),
    .ok_count      (ok_count),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [39:0] frame;
    int          spacing;
    int          kind;
    logic [31:0] bytes;
    logic [7:0]  ok;
    logic [7:0]  err;
  } vec_t;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] bytes;
    logic [7:0]  ok;
    logic [7:0]  err;
    logic        busy;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [31:0] bytes,
                      input logic [7:0] ok, input logic [7:0] err, input logic b);
    sb_t e;
    e.kind  = kind;
    e.cyc   = c;
    e.bytes = bytes;
    e.ok    = ok;
    e.err   = err;
    e.busy  = b;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic fs, input logic bv, input logic bval);
    @(negedge clk);
    frame_start = fs;
    bit_valid   = bv;
    bit_value   = bval;
  endtask

  // Sends the first nbits of f MSB-first, each preceded by spacing idle cycles.
  task automatic send_bits(input logic [39:0] f, input int nbits, input int spacing,
                           output int last);
    last = 0;
    for (int i = 0; i < nbits; i++) begin
      repeat (spacing) drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, f[39-i]);
      last = cyc;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bytes"}, {humidity_int, humidity_dec, temp_int, temp_dec}, 32'h0);
    chk({tag, "_ok_count"}, ok_count, 8'h0);
    chk({tag, "_err_count"}, err_count, 8'h0);
    chk({tag, "_pulses"}, {data_valid, checksum_error, timeout_error}, 3'b000);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Monitor: pops one expectation per status pulse and flags missed pulses.
  sb_t e_mon;
  int  npulse;
  int  kind_act;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      npulse = int'(data_valid) + int'(checksum_error) + int'(timeout_error);
      if (npulse > 1) chk("pulse_exclusive", npulse, 1);
      if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
        e_mon = sb_q.pop_front();
        chk("missed_pulse_cycle", cyc, e_mon.cyc);
      end
      if (npulse != 0) begin
        kind_act = data_valid ? K_DV : (checksum_error ? K_CS : K_TO);
        $display("pulse kind=%0d cycle=%0d bytes=%02h%02h%02h%02h ok=%0d err=%0d busy=%0b",
                 kind_act, cyc, humidity_int, humidity_dec, temp_int, temp_dec,
                 ok_count, err_count, busy);
        if (sb_q.size() == 0) begin
          chk("unexpected_pulse", kind_act, 99);
        end else begin
          e_mon = sb_q.pop_front();
          chk("pulse_kind", kind_act, e_mon.kind);
          chk("pulse_cycle", cyc, e_mon.cyc);
          chk("data_bytes", {humidity_int, humidity_dec, temp_int, temp_dec}, e_mon.bytes);
          chk("ok_count", ok_count, e_mon.ok);
          chk("err_count", err_count, e_mon.err);
          chk("busy_at_pulse", busy, e_mon.busy);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;

    vecs[0] = '{40'h2300190541, 0,  K_DV, 32'h23001905, 8'd1, 8'd0};
    vecs[1] = '{40'h2300190540, 0,  K_CS, 32'h23001905, 8'd1, 8'd1};
    vecs[2] = '{40'hFFFF010201, 0,  K_DV, 32'hFFFF0102, 8'd2, 8'd1};
    vecs[3] = '{40'h0000000000, 49, K_DV, 32'h00000000, 8'd3, 8'd1};
    vecs[4] = '{40'h1234567814, 3,  K_DV, 32'h12345678, 8'd4, 8'd1};

    rst = 1'b0;
    frame_start = 1'b0;
    bit_valid = 1'b0;
    bit_value = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Table-driven frames: good, bad checksum, wrapping sum, slowest legal gap, dense bits.
    foreach (vecs[i]) begin
      drive(1'b1, 1'b0, 1'b0);
      send_bits(vecs[i].frame, 40, vecs[i].spacing, n);
      push(vecs[i].kind, n + 2, vecs[i].bytes, vecs[i].ok, vecs[i].err, 1'b0);
      repeat (4) drive(1'b0, 1'b0, 1'b0);
    end

    // Timeout after 20 bits, then timeout straight after frame_start.
    drive(1'b1, 1'b0, 1'b0);
    send_bits(40'hA5A5A5A5A5, 20, 0, m);
    push(K_TO, m + TO + 1, 32'h12345678, 8'd4, 8'd2, 1'b0);
    repeat (TO) drive(1'b0, 1'b0, 1'b0);
    chk("busy_before_timeout", busy, 1'b1);
    repeat (5) drive(1'b0, 1'b0, 1'b0);

    drive(1'b1, 1'b0, 1'b0);
    m = cyc;
    push(K_TO, m + TO + 1, 32'h12345678, 8'd4, 8'd3, 1'b0);
    repeat (TO + 5) drive(1'b0, 1'b0, 1'b0);

    drive(1'b1, 1'b0, 1'b0);
    send_bits(40'h2300190541, 40, 0, n);
    push(K_DV, n + 2, 32'h23001905, 8'd5, 8'd3, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 1'b0);

    // Restart after 17 random bits; the bit coinciding with frame_start is dropped.
    drive(1'b1, 1'b0, 1'b0);
    repeat (17) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    drive(1'b1, 1'b1, 1'b1);
    send_bits(40'h2300190541, 40, 0, n);
    push(K_DV, n + 2, 32'h23001905, 8'd6, 8'd3, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 1'b0);

    // 40th-bit-equivalent strobe together with frame_start restarts instead of checking.
    drive(1'b1, 1'b0, 1'b0);
    send_bits(40'hFFFF010201, 39, 0, n);
    drive(1'b1, 1'b1, 1'b1);
    send_bits(40'hFFFF010201, 40, 1, n);
    push(K_DV, n + 2, 32'hFFFF0102, 8'd7, 8'd3, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 1'b0);

    // frame_start in the CHECK cycle (with an ignored strobe) chains the next frame.
    drive(1'b1, 1'b0, 1'b0);
    send_bits(40'h2300190541, 40, 0, n);
    push(K_DV, n + 2, 32'h23001905, 8'd8, 8'd3, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    send_bits(40'hFFFF010201, 40, 0, n);
    push(K_DV, n + 2, 32'hFFFF0102, 8'd9, 8'd3, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 1'b0);

    // Asynchronous reset after 30 bits: outputs clear before any clock edge.
    drive(1'b1, 1'b0, 1'b0);
    send_bits(40'h2300190541, 30, 0, n);
    chk("pre_reset_busy", busy, 1'b1);
    chk("pre_reset_ok_count", ok_count, 8'd9);
    bit_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 45; i++) begin
      drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      chk("busy_without_start", busy, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    check_all_zero("after_orphan_bits");

    // Error counter saturates at 255.
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      m = cyc;
      push(K_TO, m + TO + 1, 32'h0, 8'd0, (i < 255) ? 8'(i + 1) : 8'd255, 1'b0);
      repeat (TO + 2) drive(1'b0, 1'b0, 1'b0);
    end

    // Ok counter wraps from 255 to 0.
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      send_bits(40'h0, 40, 0, n);
      push(K_DV, n + 2, 32'h0, 8'(i + 1), 8'd255, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end

    repeat (10) drive(1'b0, 1'b0, 1'b0);
    chk("scoreboard_empty", sb_q.size(), 0);
    chk("final_ok_count", ok_count, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dht11_frame_assembler.md
# dht11_frame_assembler

Downstream stage of the DHT11 bit receiver: consumes the per-bit strobes the receiver produces after the sensor handshake and assembles them into the 40-bit DHT11 frame. It verifies the checksum and publishes humidity and temperature bytes with a one-cycle valid pulse. It also supervises inter-bit gaps and keeps frame and error counters. Runs in the divided 1 MHz domain alongside the start and receiver modules.

## Interface
- TIMEOUT_CYCLES, default 2000: number of consecutive `clk` cycles in COLLECT without `bit_valid` that aborts the frame. At 1 MHz this is 2 ms.
- clk  in  1  divided system clock (1 MHz).
- rst  in  1  reset. Asynchronous, active-low: asserted when 0.
- frame_start  in  1  one-cycle pulse from the receiver; a new frame begins.
- bit_valid  in  1  one-cycle strobe; `bit_value` holds a decoded bit.
- bit_value  in  1  decoded bit; the first bit received is the MSB of byte 0.
- humidity_int  out  8  frame byte 0 of the last accepted frame.
- humidity_dec  out  8  frame byte 1.
- temp_int  out  8  frame byte 2.
- temp_dec  out  8  frame byte 3.
- data_valid  out  1  one-cycle pulse; the data bytes were just updated.
- checksum_error  out  1  one-cycle pulse; the frame was rejected.
- timeout_error  out  1  one-cycle pulse; the frame was aborted on an inter-bit gap.
- busy  out  1  high when the state is not IDLE.
- ok_count  out  8  accepted frames; wraps from 255 to 0.
- err_count  out  8  checksum and timeout errors combined; saturates at 255.

## Operation
- Registers:
  - `shift[39:0]`
  - `bit_cnt[5:0]`
  - `gap_cnt`, sized as clog2(TIMEOUT_CYCLES)+1 bits
  - state ∈ {IDLE, COLLECT, CHECK}
- IDLE:
  - `bit_valid` is ignored.
  - `frame_start` clears `shift`, `bit_cnt` and `gap_cnt`, then moves to COLLECT.
- COLLECT:
  - On `bit_valid`: `shift <= {shift[38:0], bit_value}`, `bit_cnt++`, `gap_cnt <= 0`.
  - On the 40th accepted bit, move to CHECK.
  - Without `bit_valid`: `gap_cnt++`. If `gap_cnt == TIMEOUT_CYCLES-1`, move to IDLE and pulse `timeout_error`.
  - `frame_start` in COLLECT restarts the frame: clears the counters and shift register and stays in COLLECT. No error pulse. If `frame_start` and `bit_valid` arrive together, `frame_start` wins and the bit is dropped.
- CHECK (lasts exactly one cycle):
  - Compute `sum = (B0+B1+B2+B3) mod 256`, where B0 = `shift[39:32]` and B4 = `shift[7:0]`.
  - Match: load B0..B3 into the data outputs, pulse `data_valid`, `ok_count++` (wrapping).
  - Mismatch: pulse `checksum_error` and keep the data outputs unchanged.
  - `bit_valid` is ignored. Next state is IDLE, or COLLECT (with cleared counters) if `frame_start` is high in the CHECK cycle; the result is still reported.
- Timeout and checksum errors each do `err_count++`, holding at 255.
- Pulses and counters are registered outputs.
- `busy` is a combinational decode of the state register.
- Reset (`rst`=0), asynchronous, at any time including mid-frame:
  - state returns to IDLE.
  - All outputs and internal registers go to 0: data bytes, pulses, both counters, `busy`.

## Timing
- Latency: with the 40th `bit_valid` high in cycle N, the state is CHECK in cycle N+1. `data_valid` or `checksum_error` is high during cycle N+2 only.
- Timeout: with the last `bit_valid` (or `frame_start`) in cycle M, `timeout_error` is high during cycle M+TIMEOUT_CYCLES+1. `busy` falls in the same cycle.
- At most one of `data_valid`, `checksum_error`, `timeout_error` is high in any cycle.
- Back-to-back `bit_valid` on consecutive cycles is accepted; there is no minimum spacing.
- Minimum frame-to-frame spacing: `frame_start` may arrive in the CHECK cycle.

## Test plan
- Good frame: `frame_start`, then bytes 0x23, 0x00, 0x19, 0x05, 0x41 MSB-first.
  - Expect `data_valid` high 1 cycle at N+2.
  - Expect `humidity_int`=35, `humidity_dec`=0, `temp_int`=25, `temp_dec`=5.
  - Expect `ok_count`=1, `err_count`=0.
- Checksum wrap: bytes 0xFF, 0xFF, 0x01, 0x02, 0x01 (sum 0x201 gives 0x01).
  - Expect `data_valid`, `humidity_int`=255, `temp_dec`=2.
- Bad checksum: after the good frame, send bytes 0x23, 0x00, 0x19, 0x05, 0x40.
  - Expect `checksum_error` for 1 cycle and data outputs still 35/0/25/5.
  - Expect `err_count`=1 and no `data_valid`.
- Timeout: TIMEOUT_CYCLES=50, send 20 bits then silence.
  - Expect `timeout_error` exactly 51 cycles after the 20th strobe and `busy`=0.
  - A following full good frame is accepted.
- Restart: `frame_start`, 17 random bits, `frame_start`, then the good frame.
  - Expect exactly one `data_valid` with correct bytes and no error pulses.
  - Also drive a 40th-bit-equivalent `bit_valid` together with `frame_start` and check the bit is dropped.
- Reset mid-frame: pull `rst` low after 30 bits.
  - Expect all outputs 0 immediately, without waiting for a clock edge.
  - After release, `bit_valid` without `frame_start` produces no pulse and `busy` stays 0.
